// File: rtl/dpu_pkg.sv
// Shared widths, LeakyReLU constants and the INT8 saturation helper used by
// the processing-element arithmetic stages.
package dpu_pkg;

  localparam int ACC_W   = 32;
  localparam int DATA_W  = 8;
  localparam int SCALE_W = 16;

  // Product of a signed ACC_W value and a zero-extended SCALE_W value.
  localparam int REQ_PROD_W = ACC_W + SCALE_W + 1;

  // LeakyReLU negative slope: 13 / 128 ~= 0.1016.
  localparam int LEAKY_MUL   = 13;
  localparam int LEAKY_SHIFT = 7;
  localparam int LEAKY_PROD_W = 36;

  localparam logic signed [DATA_W-1:0] INT8_MIN = -8'sd128;
  localparam logic signed [DATA_W-1:0] INT8_MAX = 8'sd127;

  // Clamp a wide signed value into the INT8 range.
  function automatic logic signed [DATA_W-1:0] sat_int8(
    input logic signed [REQ_PROD_W-1:0] v
  );
    logic signed [REQ_PROD_W-1:0] lo;
    logic signed [REQ_PROD_W-1:0] hi;
    lo = REQ_PROD_W'(INT8_MIN);
    hi = REQ_PROD_W'(INT8_MAX);
    if (v < lo) begin
      sat_int8 = INT8_MIN;
    end else if (v > hi) begin
      sat_int8 = INT8_MAX;
    end else begin
      sat_int8 = v[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/leaky_relu.sv
// LeakyReLU on a signed 32-bit value: positive inputs pass, negative inputs
// are scaled by 13/128 with an arithmetic shift (rounds toward -inf).
module leaky_relu
  import dpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic signed [ACC_W-1:0] x_i,
  output logic signed [ACC_W-1:0] y_o,
  output logic                    done_o
);

  logic signed [LEAKY_PROD_W-1:0] prod;
  logic signed [LEAKY_PROD_W-1:0] scaled;
  logic signed [ACC_W-1:0]        y_d;
  logic signed [ACC_W-1:0]        y_q;
  logic                           done_q;

  // 36-bit product keeps x*13 exact; the shifted value always fits back in 32 bits.
  always_comb begin
    prod   = LEAKY_PROD_W'(x_i) * LEAKY_PROD_W'(LEAKY_MUL);
    scaled = prod >>> LEAKY_SHIFT;
    if (x_i[ACC_W-1]) begin
      y_d = scaled[ACC_W-1:0];
    end else begin
      y_d = x_i;
    end
  end

  // Result register loads only on valid; done mirrors the accepted strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= valid_i;
      if (valid_i) begin
        y_q <= y_d;
      end
    end
  end

  assign y_o    = y_q;
  assign done_o = done_q;

endmodule

// File: rtl/mac_int8.sv
// INT8 x INT8 multiply plus 32-bit accumulate, one registered stage.
// The sum wraps modulo 2^32; there is deliberately no saturation.
module mac_int8
  import dpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] weight_i,
  input  logic signed [DATA_W-1:0] activation_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [ACC_W-1:0]  acc_o,
  output logic                     done_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_q;
  logic                       done_q;

  // Signed 16-bit product, sign-extended and added to the incoming partial sum.
  always_comb begin
    prod  = weight_i * activation_i;
    acc_d = acc_i + ACC_W'(prod);
  end

  // Result register loads only on valid so idle (possibly X) operands never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= valid_i;
      if (valid_i) begin
        acc_q <= acc_d;
      end
    end
  end

  assign acc_o  = acc_q;
  assign done_o = done_q;

endmodule

// File: rtl/requantize.sv
// INT32 -> INT8 requantizer: multiply by an unsigned Q0.SCALE_Q scale,
// round half up, shift down and saturate to the INT8 range.
module requantize
  import dpu_pkg::*;
#(
  parameter int SCALE_Q = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic        [SCALE_W-1:0] scale_i,
  output logic signed [DATA_W-1:0]  out_o,
  output logic                      done_o
);

  localparam logic signed [REQ_PROD_W-1:0] HALF_LSB =
    REQ_PROD_W'(1) <<< (SCALE_Q - 1);

  logic signed [REQ_PROD_W-1:0] scale_ext;
  logic signed [REQ_PROD_W-1:0] prod;
  logic signed [REQ_PROD_W-1:0] rounded;
  logic signed [REQ_PROD_W-1:0] shifted;
  logic signed [DATA_W-1:0]     out_d;
  logic signed [DATA_W-1:0]     out_q;
  logic                         done_q;

  // Scale is zero-extended so it is always treated as non-negative; the
  // 49-bit product cannot overflow and leaves headroom for the rounding add.
  always_comb begin
    scale_ext = REQ_PROD_W'($signed({1'b0, scale_i}));
    prod      = REQ_PROD_W'(acc_i) * scale_ext;
    rounded   = prod + HALF_LSB;
    shifted   = rounded >>> SCALE_Q;
    out_d     = sat_int8(shifted);
  end

  // Result register loads only on valid; done mirrors the accepted strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= valid_i;
      if (valid_i) begin
        out_q <= out_d;
      end
    end
  end

  assign out_o  = out_q;
  assign done_o = done_q;

endmodule

// File: rtl/pe_arith_units.sv
// Processing-element arithmetic set: MAC, LeakyReLU and requantizer as three
// independent single-cycle stages sharing only clock and reset.
//
// Handshake: each stage samples its operands on every rising edge where its
// valid is high. There is no ready: stages never stall, so back-to-back
// valids are all accepted. The registered result and a done pulse appear
// right after the sampling edge; done is high for one cycle per accepted
// valid and stays high across consecutive valids. With valid low the result
// register holds its last value.
module pe_arith_units
  import dpu_pkg::*;
#(
  parameter int SCALE_Q = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      mac_valid,
  input  logic signed [DATA_W-1:0]  mac_weight,
  input  logic signed [DATA_W-1:0]  mac_activation,
  input  logic signed [ACC_W-1:0]   mac_acc_in,
  output logic signed [ACC_W-1:0]   mac_acc_out,
  output logic                      mac_done,

  input  logic                      leaky_valid,
  input  logic signed [ACC_W-1:0]   leaky_x,
  output logic signed [ACC_W-1:0]   leaky_y,
  output logic                      leaky_done,

  input  logic                      req_valid,
  input  logic signed [ACC_W-1:0]   req_acc,
  input  logic        [SCALE_W-1:0] req_scale,
  output logic signed [DATA_W-1:0]  req_out,
  output logic                      req_done
);

  mac_int8 u_mac (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (mac_valid),
    .weight_i     (mac_weight),
    .activation_i (mac_activation),
    .acc_i        (mac_acc_in),
    .acc_o        (mac_acc_out),
    .done_o       (mac_done)
  );

  leaky_relu u_leaky (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (leaky_valid),
    .x_i     (leaky_x),
    .y_o     (leaky_y),
    .done_o  (leaky_done)
  );

  requantize #(
    .SCALE_Q (SCALE_Q)
  ) u_req (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (req_valid),
    .acc_i   (req_acc),
    .scale_i (req_scale),
    .out_o   (req_out),
    .done_o  (req_done)
  );

endmodule

// File: tb/tb_pe_arith_units.sv
// Directed bench for pe_arith_units: hand-computed vectors for each stage,
// pipelining, and asynchronous reset in the middle of an operation.
module tb_pe_arith_units;

  logic               clk;
  logic               rst_n;
  logic               mac_valid;
  logic signed [7:0]  mac_weight;
  logic signed [7:0]  mac_activation;
  logic signed [31:0] mac_acc_in;
  logic signed [31:0] mac_acc_out;
  logic               mac_done;
  logic               leaky_valid;
  logic signed [31:0] leaky_x;
  logic signed [31:0] leaky_y;
  logic               leaky_done;
  logic               req_valid;
  logic signed [31:0] req_acc;
  logic        [15:0] req_scale;
  logic signed [7:0]  req_out;
  logic               req_done;

  int n_cmp;
  int n_fail;
  int exp_acc;

  pe_arith_units #(.SCALE_Q(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mac_valid      (mac_valid),
    .mac_weight     (mac_weight),
    .mac_activation (mac_activation),
    .mac_acc_in     (mac_acc_in),
    .mac_acc_out    (mac_acc_out),
    .mac_done       (mac_done),
    .leaky_valid    (leaky_valid),
    .leaky_x        (leaky_x),
    .leaky_y        (leaky_y),
    .leaky_done     (leaky_done),
    .req_valid      (req_valid),
    .req_acc        (req_acc),
    .req_scale      (req_scale),
    .req_out        (req_out),
    .req_done       (req_done)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp_v), exp_v);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    mac_valid      = 1'b0;
    mac_weight     = 'x;
    mac_activation = 'x;
    mac_acc_in     = 'x;
    leaky_valid    = 1'b0;
    leaky_x        = 'x;
    req_valid      = 1'b0;
    req_acc        = 'x;
    req_scale      = 'x;
  endtask

  task automatic drive_mac(input int w, input int a, input int acc);
    mac_valid      = 1'b1;
    mac_weight     = 8'(w);
    mac_activation = 8'(a);
    mac_acc_in     = 32'(acc);
  endtask

  task automatic drive_leaky(input int x);
    leaky_valid = 1'b1;
    leaky_x     = 32'(x);
  endtask

  task automatic drive_req(input int acc, input int scale);
    req_valid = 1'b1;
    req_acc   = 32'(acc);
    req_scale = 16'(scale);
  endtask

  function automatic logic [31:0] sx8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_all();

    // Reset state, with X on idle data inputs.
    tick();
    tick();
    chk("rst_mac_out", mac_acc_out, 0);
    chk("rst_mac_done", 32'(mac_done), 0);
    chk("rst_leaky_y", leaky_y, 0);
    chk("rst_leaky_done", 32'(leaky_done), 0);
    chk("rst_req_out", sx8(req_out), 0);
    chk("rst_req_done", 32'(req_done), 0);

    // Release reset; valid on the very first edge after release.
    rst_n = 1'b1;
    drive_mac(-128, -128, 0);
    tick();
    chk("mac_minmin", mac_acc_out, 16384);
    chk("mac_minmin_done", 32'(mac_done), 1);
    idle_all();
    tick();
    chk("mac_hold", mac_acc_out, 16384);
    chk("mac_done_drop", 32'(mac_done), 0);
    chk("leaky_idle_noX", leaky_y, 0);

    // MAC wrap.
    drive_mac(1, 1, 32'h7FFF_FFFF);
    tick();
    chk("mac_wrap", mac_acc_out, 32'h8000_0000);
    idle_all();

    // MAC chain with feedback: 128 x (2 * -3).
    exp_acc = 0;
    for (int i = 0; i < 128; i++) begin
      drive_mac(2, -3, (i == 0) ? 0 : int'(mac_acc_out));
      tick();
      exp_acc = exp_acc - 6;
      chk($sformatf("mac_chain_%0d", i), mac_acc_out, 32'(exp_acc));
    end
    chk("mac_chain_done", 32'(mac_done), 1);
    chk("mac_chain_final", mac_acc_out, -768);
    idle_all();
    tick();

    // LeakyReLU vectors.
    drive_leaky(1000);  tick(); chk("leaky_p1000", leaky_y, 1000);
    chk("leaky_done", 32'(leaky_done), 1);
    drive_leaky(-1000); tick(); chk("leaky_m1000", leaky_y, -102);
    drive_leaky(0);     tick(); chk("leaky_zero", leaky_y, 0);
    drive_leaky(-1);    tick(); chk("leaky_m1", leaky_y, -1);
    idle_all();
    tick();
    chk("leaky_hold", leaky_y, -1);
    chk("leaky_done_drop", 32'(leaky_done), 0);

    // Requantize vectors, scale 655 ~= 0.01.
    drive_req(10000, 655);  tick(); chk("req_10000", sx8(req_out), 100);
    chk("req_done", 32'(req_done), 1);
    drive_req(20000, 655);  tick(); chk("req_sat_hi", sx8(req_out), 127);
    drive_req(-20000, 655); tick(); chk("req_sat_lo", sx8(req_out), -128);
    drive_req(-100, 655);   tick(); chk("req_m100", sx8(req_out), -1);
    // Round half up at scale 0.5: 1.5 -> 2, -1.5 -> -1.
    drive_req(3, 32768);    tick(); chk("req_half_pos", sx8(req_out), 2);
    drive_req(-3, 32768);   tick(); chk("req_half_neg", sx8(req_out), -1);
    drive_req(32'h8000_0000, 65535); tick(); chk("req_min_acc", sx8(req_out), -128);
    idle_all();
    tick();
    chk("req_done_drop", 32'(req_done), 0);

    // Three consecutive valids on all stages at once.
    drive_mac(5, -7, 100);  drive_leaky(128);  drive_req(100, 65535);
    tick();
    chk("pipe0_mac", mac_acc_out, 65);
    chk("pipe0_leaky", leaky_y, 128);
    chk("pipe0_req", sx8(req_out), 100);
    chk("pipe0_done", {29'd0, mac_done, leaky_done, req_done}, 3'b111);
    drive_mac(127, 127, -1); drive_leaky(-128); drive_req(3, 32768);
    tick();
    chk("pipe1_mac", mac_acc_out, 16128);
    chk("pipe1_leaky", leaky_y, -13);
    chk("pipe1_req", sx8(req_out), 2);
    chk("pipe1_done", {29'd0, mac_done, leaky_done, req_done}, 3'b111);
    drive_mac(-128, 127, 0); drive_leaky(-129); drive_req(12345, 0);
    tick();
    chk("pipe2_mac", mac_acc_out, -16256);
    chk("pipe2_leaky", leaky_y, -14);
    chk("pipe2_req", sx8(req_out), 0);
    chk("pipe2_done", {29'd0, mac_done, leaky_done, req_done}, 3'b111);
    idle_all();
    tick();
    chk("pipe_done_end", {29'd0, mac_done, leaky_done, req_done}, 3'b000);
    chk("pipe_hold_mac", mac_acc_out, -16256);

    // Reset mid-operation: valid, then drop rst_n in the following cycle.
    drive_mac(10, 10, 5); drive_leaky(77); drive_req(10000, 655);
    tick();
    chk("pre_rst_mac", mac_acc_out, 105);
    chk("pre_rst_req", sx8(req_out), 100);
    drive_mac(1, 1, 1); drive_leaky(-5); drive_req(1, 1);
    rst_n = 1'b0;
    #2;
    chk("async_rst_mac", mac_acc_out, 0);
    chk("async_rst_leaky", leaky_y, 0);
    chk("async_rst_req", sx8(req_out), 0);
    chk("async_rst_done", {29'd0, mac_done, leaky_done, req_done}, 3'b000);
    tick();
    chk("rst_held_mac", mac_acc_out, 0);
    chk("rst_held_done", {29'd0, mac_done, leaky_done, req_done}, 3'b000);
    rst_n = 1'b1;
    drive_mac(-3, 4, 20); drive_leaky(-256); drive_req(-20000, 655);
    tick();
    chk("post_rst_mac", mac_acc_out, 8);
    chk("post_rst_leaky", leaky_y, -26);
    chk("post_rst_req", sx8(req_out), -128);
    chk("post_rst_done", {29'd0, mac_done, leaky_done, req_done}, 3'b111);
    idle_all();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
